// File: rtl/seq_mlp_pkg.sv
// Shared types and the fixed network parameters for the sequential two-layer MLP.
package seq_mlp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        L0   = 2'd1,
        L1   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int unsigned WGT_W   = 8;
    localparam int unsigned BIAS_W  = 16;
    localparam int unsigned P_N_IN  = 6;
    localparam int unsigned P_N_HID = 3;

    typedef logic signed [WGT_W-1:0]  wgt_t;
    typedef logic signed [BIAS_W-1:0] bias_t;

    localparam wgt_t W0 [P_N_HID][P_N_IN] = '{
        '{-8'sd10, -8'sd32, -8'sd5,  8'sd17,  8'sd28, -8'sd45},
        '{-8'sd8,   8'sd9,   8'sd5, -8'sd11, -8'sd47,  8'sd92},
        '{ 8'sd14,  8'sd17,  8'sd10, 8'sd10, -8'sd5,  -8'sd25}
    };

    localparam wgt_t  W1 [P_N_HID] = '{8'sd7, -8'sd72, 8'sd6};
    localparam bias_t B0 [P_N_HID] = '{16'sd113, 16'sd171, 16'sd26};
    localparam bias_t B1           = -16'sd1950;

    // Table lookups; indices outside the table read as zero.
    function automatic wgt_t w0_at(input int unsigned n, input int unsigned k);
        wgt_t w;
        w = '0;
        for (int unsigned i = 0; i < P_N_HID; i++) begin
            for (int unsigned j = 0; j < P_N_IN; j++) begin
                if (i == n && j == k) begin
                    w = W0[i][j];
                end
            end
        end
        return w;
    endfunction

    function automatic wgt_t w1_at(input int unsigned n);
        wgt_t w;
        w = '0;
        for (int unsigned i = 0; i < P_N_HID; i++) begin
            if (i == n) begin
                w = W1[i];
            end
        end
        return w;
    endfunction

    function automatic bias_t b0_at(input int unsigned n);
        bias_t b;
        b = '0;
        for (int unsigned i = 0; i < P_N_HID; i++) begin
            if (i == n) begin
                b = B0[i];
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/seq_mlp_mac.sv
// Wrapping signed MAC: acc <= (preload ? bias : acc) + wgt * zero-extended operand.
module seq_mlp_mac #(
    parameter int unsigned A_W   = 8,
    parameter int unsigned B_W   = 4,
    parameter int unsigned ACC_W = 12
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_en,
    input  logic                    i_preload,
    input  logic signed [ACC_W-1:0] i_bias,
    input  logic signed [A_W-1:0]   i_wgt,
    input  logic        [B_W-1:0]   i_opnd,
    output logic signed [ACC_W-1:0] o_acc
);

    localparam int unsigned P_W = A_W + B_W + 1;
    localparam int unsigned X_W = (P_W > ACC_W) ? P_W : ACC_W;

    logic signed [P_W-1:0]   w_prod;
    logic signed [X_W-1:0]   w_prod_x;
    logic signed [ACC_W-1:0] w_addend;
    logic signed [ACC_W-1:0] w_base;
    logic signed [ACC_W-1:0] w_sum;
    logic signed [ACC_W-1:0] r_acc;

    // Product is exact; reduction to ACC_W keeps modulo semantics.
    assign w_prod   = P_W'(i_wgt) * P_W'($signed({1'b0, i_opnd}));
    assign w_prod_x = X_W'(w_prod);
    assign w_addend = ACC_W'(w_prod_x);
    assign w_base   = i_preload ? i_bias : r_acc;
    assign w_sum    = w_base + w_addend;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= w_sum;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/seq_mlp_2l.sv
// Sequential two-layer ReLU MLP: one MAC per cycle per layer, ready/valid on both sides.
module seq_mlp_2l
    import seq_mlp_pkg::*;
#(
    parameter int unsigned N_IN  = 6,
    parameter int unsigned N_HID = 3,
    parameter int unsigned IN_W  = 4,
    parameter int unsigned HID_W = 11,
    parameter int unsigned OUT_W = 18
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N_IN*IN_W-1:0]   inp,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_W:0]         out,
    output logic                   out_class
);

    localparam int unsigned ACC0_W = HID_W + 1;
    localparam int unsigned ACC1_W = OUT_W + 1;
    localparam int unsigned NRN_W  = $clog2(N_HID + 1);
    localparam int unsigned FEAT_W = (N_IN > 1) ? $clog2(N_IN) : 1;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [NRN_W-1:0]          r_nrn;
    logic [FEAT_W-1:0]         r_feat;
    logic [N_IN*IN_W-1:0]      r_inp;
    logic [HID_W-1:0]          r_hid [N_HID];
    logic [OUT_W-1:0]          r_out;
    logic                      r_out_class;
    logic                      r_out_valid;

    logic                      w_accept;
    logic                      w_last_feat;
    logic                      w_last_nrn;
    logic                      w_l1_end;
    logic                      w_l0_en;
    logic                      w_l0_pre;
    logic                      w_l1_en;
    logic                      w_l1_pre;
    logic                      w_out_load;
    logic                      w_hid_we;
    logic [NRN_W-1:0]          w_hid_widx;
    logic [IN_W-1:0]           w_feat;
    logic [HID_W-1:0]          w_hid_sel;
    logic [HID_W-1:0]          w_hid_op;
    logic [HID_W-1:0]          w_hid_relu;
    logic [OUT_W-1:0]          w_out_relu;
    wgt_t                      w_w0;
    wgt_t                      w_w1;
    logic signed [ACC0_W-1:0]  w_b0;
    logic signed [ACC1_W-1:0]  w_b1;
    logic signed [ACC0_W-1:0]  w_acc0;
    logic signed [ACC1_W-1:0]  w_acc1;

    assign in_ready    = rst_n && (r_state == IDLE);
    assign w_accept    = in_valid && in_ready;
    assign w_last_feat = (r_feat == FEAT_W'(N_IN - 1));
    assign w_last_nrn  = (r_nrn == NRN_W'(N_HID - 1));
    assign w_l1_end    = (r_nrn == NRN_W'(N_HID));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A neuron's final sum sits in the L0 accumulator while the next neuron preloads,
    // so its ReLU is written back on that preload cycle (the last one on L1 entry).
    always_comb begin
        w_state_nxt = r_state;
        w_l0_en     = 1'b0;
        w_l0_pre    = 1'b0;
        w_l1_en     = 1'b0;
        w_l1_pre    = 1'b0;
        w_out_load  = 1'b0;
        w_hid_we    = 1'b0;
        w_hid_widx  = '0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = L0;
                end
            end
            L0: begin
                w_l0_en  = 1'b1;
                w_l0_pre = (r_feat == '0);
                if (r_feat == '0 && r_nrn != '0) begin
                    w_hid_we   = 1'b1;
                    w_hid_widx = r_nrn - NRN_W'(1);
                end
                if (w_last_feat && w_last_nrn) begin
                    w_state_nxt = L1;
                end
            end
            L1: begin
                if (w_l1_end) begin
                    w_out_load  = 1'b1;
                    w_state_nxt = DONE;
                end else begin
                    w_l1_en  = 1'b1;
                    w_l1_pre = (r_nrn == '0);
                end
                if (r_nrn == '0) begin
                    w_hid_we   = 1'b1;
                    w_hid_widx = NRN_W'(N_HID - 1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_nrn  <= '0;
            r_feat <= '0;
        end else begin
            case (r_state)
                L0: begin
                    if (w_last_feat) begin
                        r_feat <= '0;
                        r_nrn  <= w_last_nrn ? '0 : r_nrn + NRN_W'(1);
                    end else begin
                        r_feat <= r_feat + FEAT_W'(1);
                    end
                end
                L1: r_nrn <= w_l1_end ? '0 : r_nrn + NRN_W'(1);
                default: begin
                    r_nrn  <= '0;
                    r_feat <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_inp <= '0;
        end else if (w_accept) begin
            r_inp <= inp;
        end
    end

    always_comb begin
        w_feat = '0;
        for (int unsigned k = 0; k < N_IN; k++) begin
            if (32'(r_feat) == k) begin
                w_feat = r_inp[k*IN_W +: IN_W];
            end
        end
    end

    always_comb begin
        w_hid_sel = '0;
        for (int unsigned j = 0; j < N_HID; j++) begin
            if (32'(r_nrn) == j) begin
                w_hid_sel = r_hid[j];
            end
        end
    end

    // Single-neuron networks read the hidden value on the cycle it is written.
    assign w_hid_op   = (N_HID == 1 && r_nrn == '0) ? w_hid_relu : w_hid_sel;

    assign w_w0       = w0_at(32'(r_nrn), 32'(r_feat));
    assign w_w1       = w1_at(32'(r_nrn));
    assign w_b0       = ACC0_W'(b0_at(32'(r_nrn)));
    assign w_b1       = ACC1_W'(B1);

    assign w_hid_relu = w_acc0[ACC0_W-1] ? '0 : w_acc0[HID_W-1:0];
    assign w_out_relu = w_acc1[ACC1_W-1] ? '0 : w_acc1[OUT_W-1:0];

    seq_mlp_mac #(
        .A_W   (WGT_W),
        .B_W   (IN_W),
        .ACC_W (ACC0_W)
    ) u_mac_l0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_en      (w_l0_en),
        .i_preload (w_l0_pre),
        .i_bias    (w_b0),
        .i_wgt     (w_w0),
        .i_opnd    (w_feat),
        .o_acc     (w_acc0)
    );

    seq_mlp_mac #(
        .A_W   (WGT_W),
        .B_W   (HID_W),
        .ACC_W (ACC1_W)
    ) u_mac_l1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_en      (w_l1_en),
        .i_preload (w_l1_pre),
        .i_bias    (w_b1),
        .i_wgt     (w_w1),
        .i_opnd    (w_hid_op),
        .o_acc     (w_acc1)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned j = 0; j < N_HID; j++) begin
                r_hid[j] <= '0;
            end
            r_out       <= '0;
            r_out_class <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            for (int unsigned j = 0; j < N_HID; j++) begin
                if (w_hid_we && 32'(w_hid_widx) == j) begin
                    r_hid[j] <= w_hid_relu;
                end
            end
            if (w_out_load) begin
                r_out       <= w_out_relu;
                r_out_class <= |w_out_relu;
                r_out_valid <= 1'b1;
            end else if (r_state == DONE && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out       = {1'b0, r_out};
    assign out_class = r_out_class;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_seq_mlp_2l.sv
// Directed and random checks of seq_mlp_2l against an independent two-layer model.
module tb_seq_mlp_2l;

    localparam int unsigned N_IN  = 6;
    localparam int unsigned N_HID = 3;
    localparam int unsigned IN_W  = 4;
    localparam int unsigned HID_W = 11;
    localparam int unsigned OUT_W = 18;
    localparam int          LAT   = 22;

    localparam int W0T [3][6] = '{
        '{-10, -32, -5, 17, 28, -45},
        '{-8, 9, 5, -11, -47, 92},
        '{14, 17, 10, 10, -5, -25}
    };
    localparam int B0T [3] = '{113, 171, 26};
    localparam int W1T [3] = '{7, -72, 6};
    localparam int B1T     = -1950;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [N_IN*IN_W-1:0] inp;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_W:0]       out;
    logic                 out_class;

    int             checks = 0;
    int             errors = 0;
    logic [OUT_W:0] sb_q [$];

    seq_mlp_2l #(
        .N_IN  (N_IN),
        .N_HID (N_HID),
        .IN_W  (IN_W),
        .HID_W (HID_W),
        .OUT_W (OUT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .inp       (inp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .out_class (out_class)
    );

    always #5 clk = ~clk;

    function automatic logic [OUT_W:0] model(input logic [23:0] x);
        int          h [3];
        int          s;
        int          f;
        logic [11:0] t0;
        logic [18:0] t1;
        for (int n = 0; n < 3; n++) begin
            s = B0T[n];
            for (int k = 0; k < 6; k++) begin
                f = 32'(x[k*4 +: 4]);
                s += W0T[n][k] * f;
            end
            t0   = 12'(s);
            h[n] = t0[11] ? 0 : 32'(t0[10:0]);
        end
        s = B1T;
        for (int n = 0; n < 3; n++) begin
            s += W1T[n] * h[n];
        end
        t1 = 19'(s);
        return t1[18] ? '0 : {1'b0, t1[17:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run_vec(input logic [23:0] x, input logic [OUT_W:0] exp, input int hold);
        int             cyc;
        logic [OUT_W:0] e;
        @(negedge clk);
        check("in_ready_idle", 32'(in_ready), 32'(1));
        inp      = x;
        in_valid = 1'b1;
        sb_q.push_back(exp);
        out_ready = (hold == 0);
        @(negedge clk);
        in_valid = 1'b0;
        inp      = 24'($urandom);
        check("in_ready_busy", 32'(in_ready), 32'(0));
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            in_valid = 1'($urandom);
            inp      = 24'($urandom);
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        check("latency", 32'(cyc), 32'(LAT));
        e = sb_q.pop_front();
        for (int i = 0; i < hold; i++) begin
            check("hold_valid", 32'(out_valid), 32'(1));
            check("hold_out", 32'(out), 32'(e));
            check("hold_in_ready", 32'(in_ready), 32'(0));
            in_valid = 1'(i & 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("out_valid", 32'(out_valid), 32'(1));
        check("out", 32'(out), 32'(e));
        check("out_class", 32'(out_class), 32'(e != '0));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("consumed_valid", 32'(out_valid), 32'(0));
        check("next_in_ready", 32'(in_ready), 32'(1));
    endtask

    initial begin
        logic [23:0] x;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        inp       = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'(0));
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_out", 32'(out), 32'(0));
        check("rst_out_class", 32'(out_class), 32'(0));
        rst_n = 1'b1;
        #1;
        check("release_in_ready", 32'(in_ready), 32'(1));

        run_vec(24'h000000, 19'd0, 2);
        run_vec(24'h0FF000, 19'd4172, 0);
        run_vec(24'hFFFFFF, 19'd0, 1);
        run_vec(24'h0FF000, 19'd4172, 10);

        // Abort a computation part-way through layer 0.
        @(negedge clk);
        check("abort_in_ready", 32'(in_ready), 32'(1));
        inp      = 24'h0FF000;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_out_valid", 32'(out_valid), 32'(0));
        check("abort_out", 32'(out), 32'(0));
        check("abort_out_class", 32'(out_class), 32'(0));
        check("abort_in_ready_low", 32'(in_ready), 32'(0));
        rst_n = 1'b1;
        #1;
        check("abort_release_ready", 32'(in_ready), 32'(1));
        run_vec(24'h0FF000, 19'd4172, 0);

        for (int i = 0; i < 1000; i++) begin
            x = 24'($urandom);
            run_vec(x, model(x), int'($urandom_range(0, 4)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
